// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver with a first-word-fall-through receive FIFO.
//   Frame is 8N1, LSB first. With UART_PARITY_EN defined the frame becomes 8E1
//   (an even-parity bit follows D7 and is checked before the byte is kept).
//   The line is double-synchronised. The start bit is re-checked at mid-bit, and
//   every later bit is sampled one bit-period after the previous sample.
//
// Optional feature macro: UART_PARITY_EN
//
// Ports
//   Clock        in   system clock, all logic on posedge
//   Reset        in   synchronous, active-low
//   BaudRate     in   0 = CPB_SLOW, 1 = CPB_FAST clocks per bit (latched at start)
//   RxDataIn     in   asynchronous serial line, idle high
//   RxRead       in   pop FIFO head (ignored while RxValid = 0)
//   ErrClear     in   clears sticky RxOverflow
//   RxDataOut    out  FIFO head byte (0 while empty)
//   RxValid      out  FIFO not empty
//   RxCount      out  FIFO occupancy, 0..FIFO_DEPTH
//   RxFrameErr   out  1-cycle pulse, stop bit sampled low
//   RxParityErr  out  1-cycle pulse, parity mismatch (constant 0 without parity)
//   RxOverflow   out  sticky, a good byte was dropped because the FIFO was full
//   DbgState     out  current receiver state encoding (debug observation)
//
// Read handshake: RxValid is the valid, RxRead is the ready. A byte is
// transferred on every posedge where RxValid && RxRead. The head then advances
// and RxDataOut shows the next byte in the following cycle.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CPB_SLOW   = 1042,
  parameter int CPB_FAST   = 521,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 11
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        BaudRate,
  input  logic                        RxDataIn,
  input  logic                        RxRead,
  input  logic                        ErrClear,
  output logic [7:0]                  RxDataOut,
  output logic                        RxValid,
  output logic [$clog2(FIFO_DEPTH):0] RxCount,
  output logic                        RxFrameErr,
  output logic                        RxParityErr,
  output logic                        RxOverflow,
  output logic [2:0]                  DbgState
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, line;
  logic [CNT_W-1:0] cpb_q, cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             half_hit, bit_hit;
  logic             cnt_clr, push, frame_err, parity_bad;

  // Two-flop synchroniser; resets to the idle (high) level so that leaving
  // reset never looks like a start bit.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RxDataIn;
      sync2_q <= sync1_q;
    end
  end
  assign line = sync2_q;

  assign half_hit = (cnt_q == (cpb_q >> 1) - CNT_W'(1));
  assign bit_hit  = (cnt_q == cpb_q - CNT_W'(1));

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!line) state_d = S_START;
      // A high line at mid start bit was only a glitch: drop back silently.
      S_START: if (half_hit) state_d = line ? S_IDLE : S_DATA;
      S_DATA:  if (bit_hit && idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
        state_d = S_PARITY;
`else
        state_d = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (bit_hit) state_d = S_STOP;
`endif
      // Deciding at mid stop bit leaves half a bit to catch a following start.
      S_STOP:  if (bit_hit) state_d = line ? S_IDLE : S_BREAK;
      // Held-low line: stay here so that a break gives a single frame error.
      S_BREAK: if (line) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    push      = 1'b0;
    frame_err = 1'b0;
    // The bit counter restarts on every state change and after each data bit.
    cnt_clr   = (state_d != state_q) || (state_q == S_DATA && bit_hit) ||
                (state_q == S_IDLE) || (state_q == S_BREAK);
    if (state_q == S_STOP && bit_hit) begin
      if (!line)            frame_err = 1'b1;
      else if (!parity_bad) push      = 1'b1;
    end
  end

  assign DbgState = state_q;

  // Receive datapath
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cpb_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      RxFrameErr <= 1'b0;
    end else begin
      RxFrameErr <= frame_err;
      // Rate is captured once per frame; later BaudRate changes wait for IDLE.
      if (state_q == S_IDLE && !line)
        cpb_q <= BaudRate ? CNT_W'(CPB_FAST) : CNT_W'(CPB_SLOW);
      cnt_q <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
      if (state_q == S_START) idx_q <= '0;
      if (state_q == S_DATA && bit_hit) begin
        idx_q   <= idx_q + 3'd1;
        shift_q <= {line, shift_q[7:1]};  // LSB first: D0 ends in bit 0
      end
    end
  end

`ifdef UART_PARITY_EN
  logic par_q;
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      par_q       <= 1'b0;
      RxParityErr <= 1'b0;
    end else begin
      if (state_q == S_PARITY && bit_hit) par_q <= line;
      // A framing error takes precedence over a parity error.
      RxParityErr <= (state_q == S_STOP) && bit_hit && line && parity_bad;
    end
  end
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad = ^{shift_q, par_q};
`else
  assign parity_bad  = 1'b0;
  assign RxParityErr = 1'b0;
`endif

  // Receive FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          fifo_full, do_pop, do_push;

  assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop    = RxRead && RxValid;
  // When full, a same-cycle pop frees the slot the push needs.
  assign do_push   = push && (!fifo_full || do_pop);

  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      RxOverflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      // A new overflow wins over a coincident clear.
      if (push && fifo_full && !do_pop) RxOverflow <= 1'b1;
      else if (ErrClear)                RxOverflow <= 1'b0;
    end
  end

  assign RxValid   = (count_q != '0);
  assign RxCount   = count_q;
  assign RxDataOut = RxValid ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo. The reference model works at the frame
//   level. Each frame the driver sends schedules one event (push, frame error
//   or parity error) at the cycle the receiver must report it:
//   fall + 3 + CPB/2 + bits*CPB. The model then applies FIFO rules on a queue.
//   The DUT is compared with this model on every negedge. Literal checks after
//   each scenario pin the model itself.
//   CPB_FAST is shortened so that the whole run stays short. The slow rate keeps
//   its real value.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB_SLOW = 1042;
  localparam int CPB_FAST = 105;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 11;
`ifdef UART_PARITY_EN
  localparam int NB = 10;   // start + 8 data + parity bit periods before mid-stop
`else
  localparam int NB = 9;
`endif
  localparam int EV_PUSH = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] data;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       BaudRate = 1'b0;
  logic       RxDataIn = 1'b1;
  logic       RxRead = 1'b0;
  logic       ErrClear = 1'b0;
  logic [7:0] RxDataOut;
  logic       RxValid;
  logic [3:0] RxCount;
  logic       RxFrameErr, RxParityErr, RxOverflow;
  logic [2:0] DbgState;

  always #5 Clock = ~Clock;

  int   cyc = 0;
  logic rd_e = 1'b0, clr_e = 1'b0, rst_e = 1'b0;
  always @(posedge Clock) begin
    cyc   <= cyc + 1;
    rd_e  <= RxRead;
    clr_e <= ErrClear;
    rst_e <= Reset;
  end

  uart_rx_fifo #(
    .CPB_SLOW(CPB_SLOW), .CPB_FAST(CPB_FAST), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Reset(Reset), .BaudRate(BaudRate), .RxDataIn(RxDataIn),
    .RxRead(RxRead), .ErrClear(ErrClear), .RxDataOut(RxDataOut),
    .RxValid(RxValid), .RxCount(RxCount), .RxFrameErr(RxFrameErr),
    .RxParityErr(RxParityErr), .RxOverflow(RxOverflow), .DbgState(DbgState)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  ev_t        ev_q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_perr = 1'b0;
  int         ferr_seen = 0;
  int         perr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  bit         have_push;
  bit         new_ovf;
  logic [7:0] push_data;

  always @(negedge Clock) begin
    if (cyc > 0) begin
      exp_ferr  = 1'b0;
      exp_perr  = 1'b0;
      have_push = 1'b0;
      new_ovf   = 1'b0;
      push_data = 8'h00;
      if (!rst_e) begin
        exp_q.delete();
        ev_q.delete();
        exp_ovf = 1'b0;
      end else begin
        for (int i = ev_q.size() - 1; i >= 0; i--) begin
          if (ev_q[i].due == cyc) begin
            case (ev_q[i].kind)
              EV_PUSH: begin have_push = 1'b1; push_data = ev_q[i].data; end
              EV_FERR: exp_ferr = 1'b1;
              default: exp_perr = 1'b1;
            endcase
            ev_q.delete(i);
          end
        end
        if (rd_e && exp_q.size() > 0) exp_q.delete(0);
        if (have_push) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(push_data);
          else new_ovf = 1'b1;
        end
        if (new_ovf)    exp_ovf = 1'b1;
        else if (clr_e) exp_ovf = 1'b0;
      end
      chk("valid", {31'd0, RxValid}, {31'd0, exp_q.size() != 0});
      chk("count", {28'd0, RxCount}, 32'(exp_q.size()));
      if (exp_q.size() != 0) chk("data", {24'd0, RxDataOut}, {24'd0, exp_q[0]});
      chk("overflow", {31'd0, RxOverflow}, {31'd0, exp_ovf});
      chk("frame_err", {31'd0, RxFrameErr}, {31'd0, exp_ferr});
      chk("parity_err", {31'd0, RxParityErr}, {31'd0, exp_perr});
      if (RxFrameErr === 1'b1)  ferr_seen++;
      if (RxParityErr === 1'b1) perr_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a posedge.
  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    RxDataIn = v;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic br, input logic stop_v,
                            input int stop_bits, input logic par_ok, input bit flip);
    int  cpb;
    ev_t e;
    cpb      = br ? CPB_FAST : CPB_SLOW;
    BaudRate = br;
    e.due    = cyc + 3 + cpb / 2 + NB * cpb;
    e.data   = d;
    if (!stop_v)      e.kind = EV_FERR;
    else if (!par_ok) e.kind = EV_PERR;
    else              e.kind = EV_PUSH;
    ev_q.push_back(e);
    hold(1'b0, cpb);
    for (int i = 0; i < 8; i++) begin
      hold(d[i], cpb);
      if (flip && i == 2) BaudRate = ~br;
    end
`ifdef UART_PARITY_EN
    hold(par_ok ? ^d : ~^d, cpb);
`endif
    hold(stop_v, stop_bits * cpb);
    RxDataIn = 1'b1;
  endtask

  task automatic read_byte(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, {31'd0, RxValid}, 32'd1);
    chk(name, {24'd0, RxDataOut}, {24'd0, exp});
    RxRead = 1'b1;
    idle(1);
    RxRead = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int f0, p0, d_due;

  initial begin
    idle(3);
    chk("rst_valid", {31'd0, RxValid}, 32'd0);
    chk("rst_count", {28'd0, RxCount}, 32'd0);
    chk("rst_ovf", {31'd0, RxOverflow}, 32'd0);
    chk("rst_state", {29'd0, DbgState}, 32'd0);
    Reset = 1'b1;
    idle(5);

    // 1: slow rate 0xA5, with BaudRate toggled mid-frame
    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b1, 1'b1);
    idle(3);
    chk("t1_valid", {31'd0, RxValid}, 32'd1);
    chk("t1_data", {24'd0, RxDataOut}, 32'hA5);
    chk("t1_count", {28'd0, RxCount}, 32'd1);
    chk("t1_no_err", 32'(ferr_seen + perr_seen), 32'd0);
    read_byte("t1_read", 8'hA5);

    // 2: fast back-to-back
    send_frame(8'h00, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    idle(3);
    chk("t2_count", {28'd0, RxCount}, 32'd3);
    read_byte("t2_r0", 8'h00);
    read_byte("t2_r1", 8'hFF);
    read_byte("t2_r2", 8'h3C);

    // 3: 200-clock glitch at slow rate
    BaudRate = 1'b0;
    hold(1'b0, 200);
    hold(1'b1, 700);
    chk("t3_state", {29'd0, DbgState}, 32'd0);
    chk("t3_count", {28'd0, RxCount}, 32'd0);
    chk("t3_no_err", 32'(ferr_seen), 32'd0);

    // 4: stop bit held low for 3 bit times, then a good byte
    f0 = ferr_seen;
    send_frame(8'h55, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    idle(20);
    chk("t4_one_ferr", 32'(ferr_seen - f0), 32'd1);
    chk("t4_count", {28'd0, RxCount}, 32'd0);
    chk("t4_state", {29'd0, DbgState}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    idle(3);
    read_byte("t4_read", 8'h12);

    // 5: overflow, clear, then a push coinciding with a read while full
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b1, 1, 1'b1, 1'b0);
    idle(5);
    chk("t5_count", {28'd0, RxCount}, 32'd8);
    chk("t5_ovf", {31'd0, RxOverflow}, 32'd1);
    ErrClear = 1'b1;
    idle(1);
    ErrClear = 1'b0;
    chk("t5_ovf_clr", {31'd0, RxOverflow}, 32'd0);
    d_due = cyc + 3 + CPB_FAST / 2 + NB * CPB_FAST;
    fork
      send_frame(8'h0A, 1'b1, 1'b1, 1, 1'b1, 1'b0);
      begin
        while (cyc < d_due - 1) idle(1);
        chk("t5_coinc_head", {24'd0, RxDataOut}, 32'h01);
        RxRead = 1'b1;
        idle(1);
        RxRead = 1'b0;
        chk("t5_coinc_count", {28'd0, RxCount}, 32'd8);
      end
    join
    idle(5);
    chk("t5_coinc_ovf", {31'd0, RxOverflow}, 32'd0);
    for (int i = 2; i <= 8; i++) read_byte("t5_drain", 8'(i));
    read_byte("t5_last", 8'h0A);
    chk("t5_empty", {31'd0, RxValid}, 32'd0);

    // 6: reset in the middle of D3, then a clean 0x7E
    BaudRate = 1'b1;
    hold(1'b0, CPB_FAST);
    hold(1'b0, CPB_FAST);
    hold(1'b1, CPB_FAST);
    hold(1'b1, CPB_FAST);
    hold(1'b1, CPB_FAST / 2);
    Reset    = 1'b0;
    RxDataIn = 1'b1;
    idle(3);
    chk("t6_rst_state", {29'd0, DbgState}, 32'd0);
    Reset = 1'b1;
    idle(3);
    f0 = ferr_seen;
    send_frame(8'h7E, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    idle(3);
    chk("t6_count", {28'd0, RxCount}, 32'd1);
    chk("t6_no_ferr", 32'(ferr_seen - f0), 32'd0);
    read_byte("t6_read", 8'h7E);
    chk("t6_empty", {31'd0, RxValid}, 32'd0);
`ifdef UART_PARITY_EN
    p0 = perr_seen;
    send_frame(8'h7E, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    idle(5);
    chk("t6_perr", 32'(perr_seen - p0), 32'd1);
    chk("t6_perr_count", {28'd0, RxCount}, 32'd0);
`else
    p0 = perr_seen;
    chk("t6_no_perr", 32'(p0), 32'd0);
`endif

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
